// File: rtl/cdc_import_fifo_if.sv
// Foreign-side toggle handshake plus local valid/ready stream of the CDC import FIFO.
// Field names follow the block's port list; the slave modport is the FIFO's view.
interface cdc_import_fifo_if #(
  parameter int pBits  = 8,
  parameter int pDepth = 4
);
  localparam int CW = $clog2(pDepth + 1);

  logic             cdc_req;
  logic [pBits-1:0] cdc_data;
  logic             cdc_ack;
  logic             out_valid;
  logic [pBits-1:0] out_data;
  logic             out_ready;
  logic [CW-1:0]    count;

  modport slave (
    input  cdc_req, cdc_data, out_ready,
    output cdc_ack, out_valid, out_data, count
  );

  modport master (
    output cdc_req, cdc_data, out_ready,
    input  cdc_ack, out_valid, out_data, count
  );
endinterface

// File: rtl/cdc_import_fifo.sv
// Receiving half of a toggle-handshake CDC: synchronises req, captures words into
// a small FWFT FIFO and only acknowledges the sender once a slot has been taken.
module cdc_import_fifo #(
  parameter int pBits  = 8,
  parameter int pDepth = 4,
  parameter int pSync  = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  cdc_import_fifo_if.slave   bus
);
  localparam int CW = $clog2(pDepth + 1);
  localparam int PW = $clog2(pDepth);

  logic [pSync-1:0] r_sync;
  logic             r_ack;
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic [pBits-1:0] r_mem [pDepth];

  logic w_req_s;
  logic w_pend;
  logic w_push;
  logic w_pop;
  logic w_empty;

  assign w_req_s = r_sync[pSync-1];
  assign w_pend  = w_req_s ^ r_ack;
  assign w_empty = (r_count == '0);
  // Full is judged on the registered count, so a pop never frees a slot for the same edge.
  assign w_push  = w_pend && (r_count < CW'(pDepth));
  assign w_pop   = !w_empty && bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync  <= '0;
      r_ack   <= 1'b0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      r_sync <= {r_sync[pSync-2:0], bus.cdc_req};
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
        r_ack  <= ~r_ack;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  // Storage is deliberately left unreset; out_data is masked while empty instead.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= bus.cdc_data;
    end
  end

  assign bus.cdc_ack   = r_ack;
  assign bus.out_valid = !w_empty;
  assign bus.out_data  = w_empty ? '0 : r_mem[r_rptr];
  assign bus.count     = r_count;
endmodule

// File: doc/cdc_import_fifo.md
Name: cdc_import_fifo

Overview:
- Receiving half of the toggle-handshake clock-domain crossing. Sits directly downstream of the exporting stage: consumes `cdc_req`/`cdc_data` from the foreign domain and returns `cdc_ack`.
- Words are captured into a small local FIFO and presented to local logic through a valid/ready stream.
- Handshake back-pressure comes from FIFO occupancy: `cdc_ack` is not toggled until a slot is free.

Parameters:
- pBits, 8, width of transferred word.
- pDepth, 4, FIFO depth in words; power of two, >= 2.
- pSync, 2, synchroniser stages on `cdc_req`; >= 2.

Ports:
- clk  in  1  local clock.
- rst_n  in  1  asynchronous active-low reset.
- cdc_req  in  1  toggle request from the foreign domain; asynchronous to clk.
- cdc_data  in  pBits  foreign-domain data; stable while a request is pending.
- cdc_ack  out  1  toggle acknowledge to the foreign domain; registered.
- out_valid  out  1  FIFO non-empty.
- out_data  out  pBits  head-of-FIFO word (first-word-fall-through).
- out_ready  in  1  local consumer accepts the head word.
- count  out  $clog2(pDepth+1)  current occupancy.

Behaviour:
- Reset (rst_n low, asynchronous assert; deassertion synchronised externally):
  - sync chain = 0, cdc_ack = 0.
  - read/write pointers = 0, count = 0, out_valid = 0.
  - out_data = 0 while empty.
  - Memory contents are not reset.
- Synchroniser:
  - sync[0] <= cdc_req; sync[i] <= sync[i-1].
  - req_s = sync[pSync-1].
  - Only req_s is used; cdc_req is never sampled directly.
- Pending: `pend = (req_s != cdc_ack)`.
- Push (single always_ff, no FSM beyond the ack bit):
  - Condition: `pend && (count < pDepth)`, evaluated on registered count.
  - On push: mem[wptr] <= cdc_data; wptr++; cdc_ack <= ~cdc_ack.
  - cdc_data is sampled only on this edge. The sender changed data no later than the req toggle, and the pSync-cycle delay guarantees it has settled.
- Pop:
  - Condition: `out_valid && out_ready`.
  - On pop: rptr++.
  - out_data = mem[rptr] combinationally; out_valid = (count != 0).
- Count:
  - +1 on push only, -1 on pop only.
  - Unchanged on simultaneous push and pop, or neither.
- Pointers: log2(pDepth) bits, wrap naturally from pDepth-1 to 0.
- Full (count == pDepth):
  - No push; cdc_ack held; sender stalls.
  - A pop in the same cycle does NOT enable a push that cycle (no bypass). Push occurs on the following edge if still pending.
- Empty: out_valid = 0; out_ready is ignored; count never underflows.
- Latency, pSync = 2, FIFO not full:
  - cdc_req toggle meeting setup before edge E0 -> cdc_ack toggles and out_valid rises on edge E2 (third rising edge incl. E0).
  - Word visible on out_data the same cycle.
- Throughput:
  - At most one word per round trip (foreign synchroniser + local pSync + 1).
  - Locally, at most one push per cycle.
- Reset mid-transfer:
  - Both domains are reset together by system convention.
  - If cdc_req = 1 from a source not reset, then after release req_s != cdc_ack. This is treated as one new word and captured normally; no error flag.
- Local consumer never observes X: out_data is forced to 0 whenever count == 0.

Test Plan:
- Single word:
  - Stimulus: cdc_data = 8'hA5, toggle cdc_req 0->1, out_ready = 0.
  - Response: cdc_ack = 1 on the 3rd edge; out_valid = 1, out_data = A5, count = 1.
  - Then out_ready = 1 for one cycle -> count = 0, out_valid = 0.
- Fill and stall:
  - Stimulus: out_ready = 0; source model sends 01, 02, 03, 04, 05.
  - Response: count reaches 4; cdc_ack stops after the 4th word (stays != req for word 05).
  - Single pop -> out_data was 01; 05 captured the edge after count = 3 is seen; count back to 4.
- Simultaneous at full:
  - Stimulus: count = 4, req pending, out_ready = 1.
  - Response: first edge count = 3, no ack toggle; next edge push, count = 4 if no pop.
- Wrap-around:
  - Stimulus: stream 20 words 00..13 with out_ready toggling pseudo-randomly.
  - Response: output order 00..13 exact; pointers wrap at least 4 times; no loss or duplicate.
- Cross-clock soak:
  - Stimulus: pair with the exporting stage; source clk 37 MHz, local clk 50 MHz, then swapped; 1000 random words.
  - Response: scoreboard matches all words in order; cdc_ack never toggles while count == pDepth.
- Reset mid-transfer:
  - Stimulus: assert rst_n = 0 with count = 2 and a request pending.
  - Response: immediately out_valid = 0, count = 0, cdc_ack = 0.
  - After release with cdc_req held at 1: exactly one word captured on the 3rd edge.
